// File: rtl/regfile_wb_writer_if.sv
// rtl/regfile_wb_writer_if.sv - write-back request handshake bundle
// Purpose: carries one write-back request (destination register + data)
//          from the execute/memory stages into the register-file writer.
// Signals:
//   WB_VALID  request valid (master -> slave)
//   WB_READY  writer can accept this cycle (slave -> master)
//   WB_ADDR   destination register (master -> slave)
//   WB_DATA   write data (master -> slave)
interface regfile_wb_writer_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          WB_VALID;
   logic          WB_READY;
   logic [AW-1:0] WB_ADDR;
   logic [DW-1:0] WB_DATA;

   modport master (output WB_VALID, WB_ADDR, WB_DATA, input WB_READY);
   modport slave  (input WB_VALID, WB_ADDR, WB_DATA, output WB_READY);
endinterface

// File: rtl/regfile_wb_writer.sv
// rtl/regfile_wb_writer.sv - FIFO-buffered owner of the register file write port
// Purpose: queues write-back requests in a DEPTH-entry FIFO, retires at most
//          one per cycle onto a registered write port, and reports pending
//          writes to two decode read addresses for hazard stalls.
// Ports:
//   CLK, RESET          clock, synchronous active-low reset
//   wb (slave)          WB_VALID/WB_READY/WB_ADDR/WB_DATA request handshake
//   HOLD                suppresses retirement this cycle
//   D_EN, D_Addr, D     registered register-file write port
//   S_Addr, T_Addr      decode read addresses
//   S_BUSY, T_BUSY      pending-write flags for S_Addr / T_Addr
//   COUNT               FIFO occupancy
module regfile_wb_writer #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     CLK,
   input  logic                     RESET,
   regfile_wb_writer_if.slave       wb,
   input  logic                     HOLD,
   output logic                     D_EN,
   output logic [AW-1:0]            D_Addr,
   output logic [DW-1:0]            D,
   input  logic [AW-1:0]            S_Addr,
   input  logic [AW-1:0]            T_Addr,
   output logic                     S_BUSY,
   output logic                     T_BUSY,
   output logic [$clog2(DEPTH):0]   COUNT
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          d_en_q, d_en_d;
   logic [AW-1:0] d_addr_q, d_addr_d;
   logic [DW-1:0] d_data_q, d_data_d;
   logic [AW-1:0] mem_addr_q [DEPTH];
   logic [AW-1:0] mem_addr_d [DEPTH];
   logic [DW-1:0] mem_data_q [DEPTH];
   logic [DW-1:0] mem_data_d [DEPTH];

   logic ready;
   logic push;
   logic pop;
   logic s_hit;
   logic t_hit;

   // Readiness looks only at the registered occupancy, so a retirement in the
   // same cycle never makes room for a push.
   assign ready       = (count_q < FULL);
   assign wb.WB_READY = ready;

   // Writes to $r0 complete the handshake but are dropped here.
   assign push = wb.WB_VALID && ready && (wb.WB_ADDR != '0);
   assign pop  = !HOLD && (count_q != '0);

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      d_en_d     = pop;
      d_addr_d   = d_addr_q;
      d_data_d   = d_data_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      if (pop) begin
         d_addr_d = mem_addr_q[rd_ptr_q];
         d_data_d = mem_data_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
         mem_addr_d[wr_ptr_q] = wb.WB_ADDR;
         mem_data_d[wr_ptr_q] = wb.WB_DATA;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         d_en_q   <= 1'b0;
         d_addr_q <= '0;
         d_data_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         d_en_q   <= d_en_d;
         d_addr_q <= d_addr_d;
         d_data_q <= d_data_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge CLK) begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
   end

   // A slot is live when its distance from the read pointer (mod DEPTH) is
   // below the occupancy; the write in flight on the port also counts.
   always_comb begin
      s_hit = 1'b0;
      t_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] offs;
         offs = PW'(i) - rd_ptr_q;
         if ({1'b0, offs} < count_q) begin
            if (mem_addr_q[i] == S_Addr) s_hit = 1'b1;
            if (mem_addr_q[i] == T_Addr) t_hit = 1'b1;
         end
      end
      if (d_en_q && (d_addr_q == S_Addr)) s_hit = 1'b1;
      if (d_en_q && (d_addr_q == T_Addr)) t_hit = 1'b1;
   end

   assign S_BUSY = (S_Addr != '0) && s_hit;
   assign T_BUSY = (T_Addr != '0) && t_hit;

   assign D_EN   = d_en_q;
   assign D_Addr = d_addr_q;
   assign D      = d_data_q;
   assign COUNT  = count_q;
endmodule

// File: doc/regfile_wb_writer.md
Name: regfile_wb_writer

Overview:
- Write-back front end that owns the register file's single write port (D_EN, D_Addr, D).
- Accepts write-back requests from the execute/memory stages over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Retires at most one entry per cycle to the register file.
- Provides pending-write scoreboard flags for the two read addresses, so decode can stall on read-after-write hazards.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
AW, 5, register address width
DW, 32, register data width

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-low reset (sampled on rising CLK)
WB_VALID  input  1  write-back request valid
WB_READY  output  1  FIFO can accept; combinational, equals (count < DEPTH)
WB_ADDR  input  AW  destination register
WB_DATA  input  DW  write data
HOLD  input  1  when 1, no entry is retired this cycle
D_EN  output  1  register-file write enable (registered)
D_Addr  output  AW  register-file write address (registered)
D  output  DW  register-file write data (registered)
S_Addr  input  AW  decode read address S
T_Addr  input  AW  decode read address T
S_BUSY  output  1  pending write to S_Addr; combinational
T_BUSY  output  1  pending write to T_Addr; combinational
COUNT  output  $clog2(DEPTH)+1  FIFO occupancy (registered)

Behaviour:
- Reset (RESET==0 at a clock edge):
  - Read pointer, write pointer and COUNT go to 0.
  - D_EN=0, D_Addr=0, D=0.
  - FIFO storage contents are don't-care.
  - Reset overrides all other activity, including mid-drain; queued entries are discarded and not written.
- Accept: push occurs when WB_VALID && WB_READY at the edge.
  - WB_READY depends on the current COUNT only. A simultaneous pop does not free space in the same cycle.
  - WB_VALID with WB_READY=0 is ignored. The source must hold the request.
- $r0 filter: a handshaken request with WB_ADDR==0 completes but is NOT enqueued (COUNT unchanged). It never produces D_EN.
- Retire: at each edge where HOLD==0 and COUNT>0:
  - The head entry is loaded into D_Addr/D.
  - D_EN=1 for the following cycle.
  - The read pointer advances.
- Otherwise D_EN=0. D_Addr and D hold their last value.
- D_EN is high for exactly one cycle per retired entry.
- Latency: a request accepted into an empty FIFO at edge k is retired at edge k+1. D_EN is high between edges k+1 and k+2, and the register file writes at edge k+2. Minimum 2 edges from accept to architectural update.
- Simultaneous push and pop:
  - COUNT unchanged.
  - With COUNT==1, the pushed entry is the new head and retires at the next edge.
- Ordering:
  - Strict FIFO.
  - Two queued writes to the same register retire in acceptance order; the last one wins.
  - No merging.
- Pointers: width $clog2(DEPTH), wrap modulo DEPTH. COUNT ranges 0..DEPTH.
- Scoreboard:
  - S_BUSY=1 iff S_Addr!=0 and S_Addr matches either (a) the address of any valid FIFO entry, or (b) D_Addr while D_EN==1 (the write in flight this cycle).
  - T_BUSY is defined identically for T_Addr.
  - Requests presented on WB_* but not yet accepted do not set BUSY.
  - After reset, both BUSY flags are 0.
- HOLD:
  - Freezes retirement only; pushes continue until full.
  - HOLD asserted while D_EN==1 does not cancel the write already in flight.

Test Plan:
1. Reset then single write → ADDR=3, DATA=0xDEADBEEF accepted at edge k → D_EN=1, D_Addr=3, D=0xDEADBEEF for exactly one cycle after edge k+1. S_Addr=3 gives S_BUSY=1 from after edge k through the D_EN cycle, then 0.
2. Fill to full with HOLD=1 → push 4 writes (r1..r4 = 0x11..0x44) → COUNT=4, WB_READY=0. A fifth request is held off. Release HOLD → D_EN pulses on 4 consecutive cycles with addresses 1,2,3,4 in order, then COUNT=0 and WB_READY=1.
3. $r0 write → WB_ADDR=0, DATA=0xFFFFFFFF handshaken → COUNT stays 0, D_EN never asserts, S_Addr=0 gives S_BUSY=0.
4. Same-register ordering and wrap → stream 10 writes alternating r7=0xA and r7=0xB with push and pop every cycle → pointers wrap, and D_EN sequence alternates 0xA,0xB ending with 0xB. T_Addr=7 is busy throughout and clears one cycle after the last retire.
5. Push/pop at full → COUNT=4, HOLD=0, WB_VALID=1 → WB_READY=0, so no push while the head retires. The next cycle COUNT=3, WB_READY=1, and the push is accepted.
6. Reset mid-drain → 3 entries queued, RESET=0 for one edge → COUNT=0, D_EN=0, BUSY flags 0, and no further D_EN pulses after reset is released.
